// File: rtl/mem_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and
// the latched request record.
package mem_pkg;

    localparam logic [1:0] MEM_OP_BYTE    = 2'b00;
    localparam logic [1:0] MEM_OP_HALF    = 2'b01;
    localparam logic [1:0] MEM_OP_WORD    = 2'b10;
    localparam logic [1:0] MEM_OP_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Copy of the request fields taken on acceptance. Everything downstream
    // uses this copy so the initiator may change its pins while busy.
    typedef struct packed {
        logic        is_write;
        logic        is_unsigned;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper: byte enables and write steering for stores, lane
// extraction plus sign/zero extension for loads. Purely combinational.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic        is_unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlanes_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte / half-word out of the stored word.
    always_comb begin
        byte_sel = rword_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    // Size-dependent enables, replicated write data and extended read data.
    // Write data is replicated into every lane so the enables alone decide
    // which bytes land.
    always_comb begin
        be_o     = 4'b0000;
        wlanes_o = 32'h0;
        rdata_o  = 32'h0;
        case (op_i)
            MEM_OP_BYTE: begin
                be_o     = 4'b0001 << lane_i;
                wlanes_o = {4{wdata_i[7:0]}};
                rdata_o  = {{24{~is_unsigned_i & byte_sel[7]}}, byte_sel};
            end
            MEM_OP_HALF: begin
                be_o     = lane_i[1] ? 4'b1100 : 4'b0011;
                wlanes_o = {2{wdata_i[15:0]}};
                rdata_o  = {{16{~is_unsigned_i & half_sel[15]}}, half_sel};
            end
            MEM_OP_WORD: begin
                be_o     = 4'b1111;
                wlanes_o = wdata_i;
                rdata_o  = rword_i;
            end
            default: begin
                be_o     = 4'b0000;
                wlanes_o = 32'h0;
                rdata_o  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory target: accepts one request, stays busy for
// WAIT_CYCLES+1 cycles, then performs the access and presents read data and
// fault flags until the initiator drops its request.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        available,
    input  logic        is_write,
    input  logic        is_unsigned,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        busy,
    output logic        op_fault,
    output logic        addr_fault,
    output logic        access_fault
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_req_t    req_q, req_d;
    logic [31:0] out_q, out_d;
    logic        busy_q, busy_d;
    logic        opf_q, opf_d;
    logic        addrf_q, addrf_d;
    logic        accf_q, accf_d;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             oor, misalign, op_bad, fault_any;
    logic             do_access, mem_we;
    logic [3:0]       be;
    logic [31:0]      wlanes, rdata, rword;

    // Address decode and fault classification of the latched request.
    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    always_comb begin
        offset    = req_q.addr - BASE_ADDR;
        oor       = (offset >= SPAN);
        idx       = offset[IDX_W+1:2];
        op_bad    = (req_q.op == MEM_OP_INVALID);
        misalign  = ((req_q.op == MEM_OP_WORD) && (req_q.addr[1:0] != 2'b00)) ||
                    ((req_q.op == MEM_OP_HALF) && req_q.addr[0]);
        fault_any = op_bad | misalign | oor;
        rword     = mem_q[idx];
        do_access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
        // A reset on the completing edge cancels the store.
        mem_we    = do_access && reset && req_q.is_write && !fault_any;
    end

    mem_lane_align u_align (
        .op_i          (req_q.op),
        .lane_i        (req_q.addr[1:0]),
        .is_unsigned_i (req_q.is_unsigned),
        .wdata_i       (req_q.wdata),
        .rword_i       (rword),
        .be_o          (be),
        .wlanes_o      (wlanes),
        .rdata_o       (rdata)
    );

    // Request FSM: accept in IDLE, count down in WAIT, hold results in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        out_d   = out_q;
        busy_d  = busy_q;
        opf_d   = opf_q;
        addrf_d = addrf_q;
        accf_d  = accf_q;
        case (state_q)
            ST_IDLE: begin
                if (available) begin
                    req_d   = '{is_write:    is_write,
                                is_unsigned: is_unsigned,
                                op:          op,
                                addr:        addr,
                                wdata:       in};
                    cnt_d   = 4'(WAIT_CYCLES);
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                    opf_d   = op_bad;
                    addrf_d = misalign;
                    accf_d  = fault_any;
                    // Writes and faulting accesses present zero.
                    out_d   = (fault_any || req_q.is_write) ? 32'h0 : rdata;
                end
            end
            ST_DONE: begin
                // Stay here while the initiator keeps available high so a
                // held request is not taken as a second access.
                if (!available) begin
                    state_d = ST_IDLE;
                    opf_d   = 1'b0;
                    addrf_d = 1'b0;
                    accf_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            out_q   <= 32'h0;
            busy_q  <= 1'b0;
            opf_q   <= 1'b0;
            addrf_q <= 1'b0;
            accf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            opf_q   <= opf_d;
            addrf_q <= addrf_d;
            accf_q  <= accf_d;
        end
    end

    // Storage with per-byte write enables; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && be[b]) begin
                mem_q[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    assign out          = out_q;
    assign busy         = busy_q;
    assign op_fault     = opf_q;
    assign addr_fault   = addrf_q;
    assign access_fault = accf_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, a reset-abort sequence and
// randomized accesses checked against a byte-addressed reference memory.
module tb_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          WC    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        available = 1'b0;
    logic        is_write = 1'b0;
    logic        is_unsigned = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] in_d = 32'h0;
    logic [31:0] out_w;
    logic        busy, op_fault, addr_fault, access_fault;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mb [0:DEPTH*4-1];

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .available    (available),
        .is_write     (is_write),
        .is_unsigned  (is_unsigned),
        .op           (op),
        .addr         (addr),
        .in           (in_d),
        .out          (out_w),
        .busy         (busy),
        .op_fault     (op_fault),
        .addr_fault   (addr_fault),
        .access_fault (access_fault)
    );

    typedef struct {
        logic        w;
        logic        uns;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          hold;
        logic        chk_out;
        logic [31:0] exp_out;
        logic [2:0]  exp_f;   // {op_fault, addr_fault, access_fault}
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {op_fault, addr_fault, access_fault};
    endfunction

    // Reference: memory is a little-endian byte array; sizes are byte counts.
    task automatic model(input logic w, input logic uns, input logic [1:0] o_p,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] o, output logic [2:0] f);
        int     n;
        longint la;
        longint off;
        bit     opf, mis, oor;
        logic [31:0] v;
        n   = (o_p == 2'd0) ? 1 : (o_p == 2'd1) ? 2 : 4;
        la  = longint'(a);
        opf = (o_p == 2'd3);
        mis = ((o_p == 2'd2) && (a % 4 != 0)) || ((o_p == 2'd1) && (a % 2 != 0));
        oor = (la < longint'(BASE)) || (la >= longint'(BASE) + DEPTH * 4);
        f   = {opf, mis, opf | mis | oor};
        o   = 32'h0;
        if (opf || mis || oor) return;
        off = la - longint'(BASE);
        if (w) begin
            for (int i = 0; i < n; i++) mb[int'(off) + i] = d[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mb[int'(off) + i]) << (8 * i));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            o = v;
        end
    endtask

    // One full handshake. Pins are scrambled while busy; the result is
    // sampled in DONE, optionally held there with available high.
    task automatic run(input logic w, input logic uns, input logic [1:0] o_p,
                       input logic [31:0] a, input logic [31:0] d, input int hold,
                       input logic [2:0] exp_f,
                       output logic [31:0] rout, output logic [2:0] rf, output int bcnt);
        int guard;
        guard = 0;
        @(negedge clk);
        is_write = w; is_unsigned = uns; op = o_p; addr = a; in_d = d; available = 1'b1;
        bcnt = 0;
        @(posedge clk); #1;
        while (busy && guard < 40) begin
            bcnt++;
            guard++;
            if (bcnt == 1) chk("faults_while_busy", 32'(flags()), 32'h0);
            @(negedge clk);
            is_write = 1'($urandom); is_unsigned = 1'($urandom);
            op = 2'($urandom); addr = $urandom; in_d = $urandom;
            @(posedge clk); #1;
        end
        if (guard >= 40) chk("busy_timeout", 32'(busy), 32'h0);
        rout = out_w;
        rf   = flags();
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_busy", 32'(busy), 32'h0);
            chk("hold_faults", 32'(flags()), 32'(exp_f));
        end
        @(negedge clk);
        available = 1'b0;
        @(posedge clk); #1;
        chk("faults_after_done", 32'(flags()), 32'h0);
    endtask

    function automatic vec_t mk(logic w, logic uns, logic [1:0] o_p, logic [31:0] a,
                                logic [31:0] d, int hold, logic co, logic [31:0] eo,
                                logic [2:0] ef);
        vec_t v;
        v.w = w; v.uns = uns; v.op = o_p; v.addr = a; v.data = d; v.hold = hold;
        v.chk_out = co; v.exp_out = eo; v.exp_f = ef;
        return v;
    endfunction

    initial begin
        vec_t        vt[$];
        logic [31:0] ro, eo;
        logic [2:0]  rf, ef;
        int          bc, sel;
        logic        w, uns;
        logic [1:0]  o_p;
        logic [31:0] a, d;

        vt.push_back(mk(1, 0, 2'd2, 32'h10,   32'hDEADBEEF, 0, 0, 32'h0,        3'b000));
        vt.push_back(mk(0, 0, 2'd2, 32'h10,   32'h0,        0, 1, 32'hDEADBEEF, 3'b000));
        vt.push_back(mk(0, 0, 2'd0, 32'h13,   32'h0,        0, 1, 32'hFFFFFFDE, 3'b000));
        vt.push_back(mk(0, 1, 2'd0, 32'h13,   32'h0,        0, 1, 32'h000000DE, 3'b000));
        vt.push_back(mk(0, 0, 2'd1, 32'h10,   32'h0,        0, 1, 32'hFFFFBEEF, 3'b000));
        vt.push_back(mk(0, 1, 2'd1, 32'h12,   32'h0,        0, 1, 32'h0000DEAD, 3'b000));
        vt.push_back(mk(1, 0, 2'd0, 32'h11,   32'h0000005A, 0, 0, 32'h0,        3'b000));
        vt.push_back(mk(0, 0, 2'd2, 32'h10,   32'h0,        0, 1, 32'hDEAD5AEF, 3'b000));
        vt.push_back(mk(0, 0, 2'd2, 32'h12,   32'h0,        2, 1, 32'h0,        3'b011));
        vt.push_back(mk(0, 0, 2'd1, 32'h11,   32'h0,        0, 1, 32'h0,        3'b011));
        vt.push_back(mk(0, 0, 2'd3, 32'h10,   32'h0,        0, 1, 32'h0,        3'b101));
        vt.push_back(mk(1, 0, 2'd2, 32'h0,    32'h11111111, 0, 0, 32'h0,        3'b000));
        vt.push_back(mk(1, 0, 2'd2, 32'h1000, 32'hBADBADBA, 0, 0, 32'h0,        3'b001));
        vt.push_back(mk(0, 0, 2'd2, 32'h1000, 32'h0,        0, 1, 32'h0,        3'b001));
        vt.push_back(mk(0, 0, 2'd2, 32'h0,    32'h0,        0, 1, 32'h11111111, 3'b000));
        vt.push_back(mk(0, 0, 2'd2, 32'h10,   32'h0,        3, 1, 32'hDEAD5AEF, 3'b000));
        vt.push_back(mk(1, 0, 2'd2, 32'h20,   32'hAAAA5555, 0, 0, 32'h0,        3'b000));
        vt.push_back(mk(0, 0, 2'd2, 32'h20,   32'h0,        0, 1, 32'hAAAA5555, 3'b000));

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_out", out_w, 32'h0);
        chk("reset_faults", 32'(flags()), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors.
        foreach (vt[i]) begin
            run(vt[i].w, vt[i].uns, vt[i].op, vt[i].addr, vt[i].data, vt[i].hold,
                vt[i].exp_f, ro, rf, bc);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(WC + 1));
            chk($sformatf("vec%0d_faults", i), 32'(rf), 32'(vt[i].exp_f));
            if (vt[i].chk_out) chk($sformatf("vec%0d_out", i), ro, vt[i].exp_out);
        end

        // Reset in the middle of a write to 0x20 (out still holds AAAA5555).
        @(negedge clk);
        is_write = 1'b1; is_unsigned = 1'b0; op = 2'd2; addr = 32'h20;
        in_d = 32'h12345678; available = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy_before", 32'(busy), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_out", out_w, 32'h0);
        chk("abort_faults", 32'(flags()), 32'h0);
        @(negedge clk);
        reset = 1'b1; available = 1'b0;
        @(posedge clk);
        run(0, 0, 2'd2, 32'h20, 32'h0, 0, 3'b000, ro, rf, bc);
        chk("abort_storage", ro, 32'hAAAA5555);

        // Randomized phase: seed a 64-byte window, then mixed accesses.
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model(1, 0, 2'd2, 32'(i * 4), d, eo, ef);
            run(1, 0, 2'd2, 32'(i * 4), d, 0, ef, ro, rf, bc);
            chk("seed_faults", 32'(rf), 32'(ef));
        end
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(9, 0));
            if (sel == 0)      a = 32'h1000 + $urandom_range(15, 0);
            else if (sel == 1) a = 32'hFFFF_FFF0 + $urandom_range(15, 0);
            else               a = $urandom_range(63, 0);
            o_p = ($urandom_range(7, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
            w   = 1'($urandom);
            uns = 1'($urandom);
            d   = $urandom;
            model(w, uns, o_p, a, d, eo, ef);
            run(w, uns, o_p, a, d, int'($urandom_range(2, 0)), ef, ro, rf, bc);
            chk($sformatf("rnd%0d_busy_cycles", i), 32'(bc), 32'(WC + 1));
            chk($sformatf("rnd%0d_faults a=%h op=%0d", i, a, o_p), 32'(rf), 32'(ef));
            if (!w) chk($sformatf("rnd%0d_out a=%h op=%0d u=%0d", i, a, o_p, uns), ro, eo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
